// File: rtl/alu_defs.sv
// ============================================================================
// alu_defs : shared ALU control, mul/div op and sequencer state encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_defs;

    localparam logic [3:0] ALU_AND      = 4'b0000;
    localparam logic [3:0] ALU_OR       = 4'b0001;
    localparam logic [3:0] ALU_ADD      = 4'b0100;
    localparam logic [3:0] ALU_SUBTRACT = 4'b0110;
    localparam logic [3:0] ALU_SLT      = 4'b0111;
    localparam logic [3:0] ALU_NOR      = 4'b1100;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_NEG_A  = 3'd1;
    localparam logic [2:0] S_NEG_B  = 3'd2;
    localparam logic [2:0] S_ITER   = 3'd3;
    localparam logic [2:0] S_NEG_LO = 3'd4;
    localparam logic [2:0] S_NEG_HI = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

endpackage

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// muldiv_sequencer : MULT/MULTU/DIV/DIVU into HI/LO using the shared ALU
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_sequencer
    import alu_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_by_zero,
    output logic            alu_req,
    input  logic            alu_grant,
    output logic [XLEN-1:0] alu_operand0,
    output logic [XLEN-1:0] alu_operand1,
    output logic [4:0]      alu_shamt,
    output logic [3:0]      alu_control,
    input  logic [XLEN-1:0] alu_result
);

    logic [2:0]      r_state;
    logic [5:0]      r_cnt;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic            r_is_div;
    logic            r_sign_a;
    logic            r_sign_b;
    logic            r_lo_zero;
    logic            r_dbz;

    logic [XLEN-1:0] w_rem;
    logic            w_carry;
    logic            w_signed;

    assign w_rem    = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
    assign w_carry  = (alu_result < r_hi);
    assign w_signed = op[0];

    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done        = (r_state == S_DONE);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;
    assign alu_shamt   = 5'd0;

    always_comb begin
        alu_req      = 1'b0;
        alu_operand0 = '0;
        alu_operand1 = '0;
        alu_control  = ALU_AND;
        case (r_state)
            S_NEG_A: begin
                alu_req      = 1'b1;
                alu_operand1 = r_lo;
                alu_control  = ALU_SUBTRACT;
            end
            S_NEG_B: begin
                alu_req      = 1'b1;
                alu_operand1 = r_b;
                alu_control  = ALU_SUBTRACT;
            end
            S_ITER: begin
                alu_req = 1'b1;
                if (r_is_div) begin
                    alu_operand0 = w_rem;
                    alu_operand1 = r_b;
                    alu_control  = ALU_SUBTRACT;
                end else begin
                    alu_operand0 = r_hi;
                    alu_operand1 = r_lo[0] ? r_b : '0;
                    alu_control  = ALU_ADD;
                end
            end
            S_NEG_LO: begin
                alu_req      = 1'b1;
                alu_operand1 = r_lo;
                alu_control  = ALU_SUBTRACT;
            end
            S_NEG_HI: begin
                alu_req = 1'b1;
                // Borrow from the low word turns 0-hi into ~hi unless lo was zero
                alu_operand0 = (!r_is_div && !r_lo_zero) ? '1 : '0;
                alu_operand1 = r_hi;
                alu_control  = ALU_SUBTRACT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_is_div  <= 1'b0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_lo_zero <= 1'b0;
            r_dbz     <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_is_div <= op[1];
                r_cnt    <= '0;
                r_b      <= rt_val;
                r_sign_a <= w_signed && rs_val[XLEN-1];
                r_sign_b <= w_signed && rt_val[XLEN-1];
                if (op[1] && (rt_val == '0)) begin
                    r_hi    <= rs_val;
                    r_lo    <= '1;
                    r_dbz   <= 1'b1;
                    r_state <= S_DONE;
                end else begin
                    r_hi  <= '0;
                    r_lo  <= rs_val;
                    r_dbz <= 1'b0;
                    if (w_signed && rs_val[XLEN-1])
                        r_state <= S_NEG_A;
                    else if (w_signed && rt_val[XLEN-1])
                        r_state <= S_NEG_B;
                    else
                        r_state <= S_ITER;
                end
            end
        end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
        end else if (alu_grant) begin
            case (r_state)
                S_NEG_A: begin
                    r_lo    <= alu_result;
                    r_state <= r_sign_b ? S_NEG_B : S_ITER;
                end
                S_NEG_B: begin
                    r_b     <= alu_result;
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    if (r_is_div) begin
                        if (r_hi[XLEN-1] || (w_rem >= r_b)) begin
                            r_hi <= alu_result;
                            r_lo <= {r_lo[XLEN-2:0], 1'b1};
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= {r_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        r_hi <= {w_carry, alu_result[XLEN-1:1]};
                        r_lo <= {alu_result[0], r_lo[XLEN-1:1]};
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(XLEN - 1)) begin
                        if (r_sign_a ^ r_sign_b)
                            r_state <= S_NEG_LO;
                        else if (r_is_div && r_sign_a)
                            r_state <= S_NEG_HI;
                        else
                            r_state <= S_DONE;
                    end
                end
                S_NEG_LO: begin
                    r_lo      <= alu_result;
                    r_lo_zero <= (r_lo == '0);
                    r_state   <= (!r_is_div || r_sign_a) ? S_NEG_HI : S_DONE;
                end
                S_NEG_HI: begin
                    r_hi    <= alu_result;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// tb_muldiv_sequencer : directed self-checking bench for muldiv_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;
    logic        alu_req;
    logic        alu_grant;
    logic [31:0] alu_operand0;
    logic [31:0] alu_operand1;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;

    int checks   = 0;
    int failures = 0;
    int drop_from = -1;
    int drop_to   = -1;
    int spur_cyc  = -1;

    always #5 clk = ~clk;

    // Reference ALU living outside the sequencer
    always_comb begin
        case (alu_control)
            4'b0100: alu_result = alu_operand0 + alu_operand1;
            4'b0110: alu_result = alu_operand0 - alu_operand1;
            4'b0000: alu_result = alu_operand0 & alu_operand1;
            default: alu_result = 32'h0;
        endcase
    end

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo),
        .div_by_zero  (div_by_zero),
        .alu_req      (alu_req),
        .alu_grant    (alu_grant),
        .alu_operand0 (alu_operand0),
        .alu_operand1 (alu_operand1),
        .alu_shamt    (alu_shamt),
        .alu_control  (alu_control),
        .alu_result   (alu_result)
    );

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        logic [31:0] snap_hi;
        logic [31:0] snap_lo;
        snap_hi = 32'h0;
        snap_lo = 32'h0;
        @(posedge clk); #1;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'b00; rs_val = 32'h0; rt_val = 32'h0;
        cyc = 1;
        while (!done && cyc < 100) begin
            alu_grant = !(cyc >= drop_from && cyc < drop_to);
            if (cyc == drop_from) begin
                snap_hi = hi;
                snap_lo = lo;
            end
            if (cyc == drop_to) begin
                checks++;
                if (hi !== snap_hi || lo !== snap_lo || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL freeze hi=%h lo=%h busy=%b exp hi=%h lo=%h busy=1",
                             hi, lo, busy, snap_hi, snap_lo);
                end
            end
            if (cyc == spur_cyc) begin
                start = 1'b1; op = 2'b10; rs_val = 32'h1; rt_val = 32'h0;
            end else begin
                start = 1'b0; op = 2'b00; rs_val = 32'h0; rt_val = 32'h0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        alu_grant = 1'b1;
        start     = 1'b0;
        checks++;
        if (!done || busy) begin
            failures++;
            $display("FAIL done_pulse done=%b busy=%b exp done=1 busy=0", done, busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = 32'h0; rt_val = 32'h0;
        alu_grant = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, alu_req, div_by_zero} !== 4'b0000 || hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b req=%b dbz=%b hi=%h lo=%h exp all 0",
                     busy, done, alu_req, div_by_zero, hi, lo);
        end
        checks++;
        if (alu_control !== 4'b0000 || alu_operand0 !== 32'h0 || alu_operand1 !== 32'h0
            || alu_shamt !== 5'd0) begin
            failures++;
            $display("FAIL idle_alu ctrl=%b op0=%h op1=%h shamt=%0d exp 0/0/0/0",
                     alu_control, alu_operand0, alu_operand1, alu_shamt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_multu;
        int cyc;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        checks++;
        if (cyc !== 33 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            failures++;
            $display("FAIL multu_max cyc=%0d hi=%h lo=%h exp cyc=33 hi=fffffffe lo=00000001",
                     cyc, hi, lo);
        end
    endtask

    task automatic test_mult_signed;
        int cyc;
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, cyc);
        checks++;
        if (cyc !== 36 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            failures++;
            $display("FAIL mult_neg cyc=%0d hi=%h lo=%h exp cyc=36 hi=ffffffff lo=fffffff1",
                     cyc, hi, lo);
        end
    endtask

    task automatic test_div_signed;
        int cyc;
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, cyc);
        checks++;
        if (cyc !== 36 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL div_neg cyc=%0d hi=%h lo=%h exp cyc=36 hi=ffffffff lo=fffffffd",
                     cyc, hi, lo);
        end
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        checks++;
        if (cyc !== 36 || hi !== 32'h0 || lo !== 32'h8000_0000 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL div_ovf cyc=%0d hi=%h lo=%h dbz=%b exp cyc=36 hi=0 lo=80000000 dbz=0",
                     cyc, hi, lo, div_by_zero);
        end
    endtask

    task automatic test_div_by_zero;
        int cyc;
        run_op(2'b10, 32'h0000_1234, 32'h0, cyc);
        checks++;
        if (cyc !== 1 || div_by_zero !== 1'b1 || hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL divu_zero cyc=%0d dbz=%b hi=%h lo=%h exp cyc=1 dbz=1 hi=1234 lo=ffffffff",
                     cyc, div_by_zero, hi, lo);
        end
        @(posedge clk); #1;
        checks++;
        if (div_by_zero !== 1'b1 || hi !== 32'h1234) begin
            failures++;
            $display("FAIL dbz_hold dbz=%b hi=%h exp dbz=1 hi=1234", div_by_zero, hi);
        end
    endtask

    task automatic test_divu;
        int cyc;
        run_op(2'b10, 32'd100, 32'd7, cyc);
        checks++;
        if (cyc !== 33 || hi !== 32'd2 || lo !== 32'd14 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL divu cyc=%0d hi=%h lo=%h dbz=%b exp cyc=33 hi=2 lo=e dbz=0",
                     cyc, hi, lo, div_by_zero);
        end
    endtask

    task automatic test_grant_stall;
        int cyc;
        drop_from = 5;
        drop_to   = 10;
        run_op(2'b00, 32'd6, 32'd7, cyc);
        drop_from = -1;
        drop_to   = -1;
        checks++;
        if (cyc !== 38 || hi !== 32'h0 || lo !== 32'd42) begin
            failures++;
            $display("FAIL grant_stall cyc=%0d hi=%h lo=%h exp cyc=38 hi=0 lo=2a", cyc, hi, lo);
        end
    endtask

    task automatic test_busy_start;
        int cyc;
        spur_cyc = 5;
        run_op(2'b00, 32'd6, 32'd7, cyc);
        spur_cyc = -1;
        checks++;
        if (cyc !== 33 || hi !== 32'h0 || lo !== 32'd42 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL busy_start cyc=%0d hi=%h lo=%h dbz=%b exp cyc=33 hi=0 lo=2a dbz=0",
                     cyc, hi, lo, div_by_zero);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; rs_val = 32'd6; rt_val = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || alu_req !== 1'b1 || alu_control !== 4'b0100) begin
            failures++;
            $display("FAIL iter_req busy=%b req=%b ctrl=%b exp 1/1/0100", busy, alu_req, alu_control);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || alu_req !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid busy=%b done=%b req=%b hi=%h lo=%h exp all 0",
                     busy, done, alu_req, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++;
        if (seen !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL no_done_after_reset pulses=%0d busy=%b exp 0/0", seen, busy);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_signed();
        test_div_signed();
        test_div_by_zero();
        test_divu();
        test_grant_stall();
        test_busy_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
